status_debounce: RTL and testbench
==================================

# status_debounce

Upstream input-conditioning stage for the interrupt/status-change block. Samples raw board status pins, synchronizes and debounces them on a prescaled tick, applies a software enable mask, and drives clean status bytes that the interrupt block compares cycle-to-cycle to raise the I2C alert. Debounced status and mask are also accessible over the I2C port-select register interface.

## Interface

Parameters:
- NUM_BYTES, 2, number of 8-bit status bytes (pin count = 8*NUM_BYTES), range 1..8
- TICK_DIV, 1000, SYSCLK cycles per debounce sample tick, range 1..65535
- DB_COUNT, 4, consecutive differing ticks required to accept a new level, range 1..15

Ports:
- SYSCLK  in  1  system clock; single clock domain
- RESET  in  1  synchronous, active-high reset
- RAW_IN  in  8*NUM_BYTES  asynchronous raw status pins
- PORT_CS  in  1  port select; one-cycle strobe per I2C access
- OFFSET_SEL  in  16  one-hot register offset select
- RD_WR  in  1  1 = read, 0 = write
- WR_DATA  in  8  write data for I2C writes
- DOUT  out  8  registered read data
- STATUS  out  8*NUM_BYTES  debounced, masked status; byte k feeds interrupt DINk
- CHG_PULSE  out  1  one-cycle pulse after any STATUS bit changes

## Operation

- Synchronizer: two flops per pin (SYNC1, SYNC2), reset to 0.
- Prescaler: counter 0..TICK_DIV-1, wraps to 0. TICK is high in the cycle when count == TICK_DIV-1. TICK_DIV = 1 gives TICK every cycle.
- Per-pin debounce: a STABLE bit and a cnt counter, 4 bits. On TICK:
  - SYNC2 != STABLE and cnt == DB_COUNT-1: STABLE <= SYNC2, cnt <= 0.
  - SYNC2 != STABLE otherwise: cnt <= cnt+1.
  - SYNC2 == STABLE: cnt <= 0.
  - Between ticks, STABLE and cnt hold.
- EN register: NUM_BYTES bytes, reset 8'hFF each. STATUS = STABLE & EN, combinational from flops. No added latency.
- Register map:
  - OFFSET_SEL[k], k < NUM_BYTES: status byte k, read-only. Writes are ignored.
  - OFFSET_SEL[NUM_BYTES+k]: EN byte k, read/write.
  - All other offsets read 8'h00; writes to them are ignored.
- Read: in a cycle with PORT_CS & RD_WR, DOUT <= selected byte. Otherwise DOUT holds.
- Write: in a cycle with PORT_CS & ~RD_WR, the selected EN byte <= WR_DATA. The new value is visible on STATUS the next cycle.
- CHG_PULSE: a register set to (STATUS != STATUS_prev). It is high for exactly the one cycle after STATUS changes, whether the change comes from debounce or an EN write.

## Timing

- Reset values: DOUT 8'h00, STATUS all 0, CHG_PULSE 0, STABLE 0, cnt 0, prescaler 0, EN all 8'hFF.
- Reset is synchronous. Asserting it mid-debounce discards partial counts; the next acquisition restarts from STABLE = 0.
- Latency, RAW_IN edge to SYNC2: 2 cycles. SYNC2 change to STATUS: between (DB_COUNT-1)*TICK_DIV+1 and DB_COUNT*TICK_DIV cycles.
- Glitch rejection: any pulse seen on fewer than DB_COUNT consecutive ticks never reaches STATUS.
- Read data is valid the cycle after the strobe and held until the next read.
- A read and a STATUS update in the same cycle return the pre-update value.
- An EN write coinciding with a debounce update: both take effect. STATUS reflects the new STABLE & new EN the next cycle, and one CHG_PULSE is produced if the net value changed.
- Counters never overflow: cnt is bounded by DB_COUNT-1, and the prescaler wraps.

## Test plan

Common setup for all scenarios: TICK_DIV=4, DB_COUNT=3, NUM_BYTES=2. Cycle 0 is the first cycle after RESET deasserts; ticks fall on cycles 3, 7, 11, ...

1. Reset: hold RESET 3 cycles with RAW_IN=16'hFFFF -> during and right after reset, STATUS=0, DOUT=0, CHG_PULSE=0. Reading EN offsets 2 and 3 returns 8'hFF.
2. Clean edge: RAW_IN[0] rises in cycle 0 and stays high -> STATUS[0]=0 through cycle 11, STATUS[0]=1 from cycle 12, CHG_PULSE=1 in cycle 13 only.
3. Glitch: RAW_IN[5] high for cycles 0-5 then low -> STATUS stays 16'h0000 and CHG_PULSE stays 0 for 40 cycles.
4. Mask: after STATUS=16'h0101, write 8'hFE to offset 2 -> STATUS=16'h0100 the next cycle, one CHG_PULSE. Reading offset 0 returns 8'h00; reading offset 2 returns 8'hFE.
5. Read hold: read offset 1 with STATUS[15:8]=8'hA5 -> DOUT=8'hA5 the next cycle. DOUT stays 8'hA5 while RAW_IN changes until the next read. Reading offset 7 gives 8'h00.
6. Reset mid-count: RAW_IN[3] rises, assert RESET at cycle 9 for 1 cycle -> STATUS[3] stays 0 until 3 full ticks after reset release, i.e. it goes high in cycle 12 counted from the reset release.

Source files
------------

// File: rtl/status_debounce.sv
// Status pin conditioning: two-flop synchronizer, tick-paced per-pin debounce,
// software enable mask, and a port-select register window for status/mask access.
module status_debounce #(
   parameter int unsigned NUM_BYTES = 2,
   parameter int unsigned TICK_DIV  = 1000,
   parameter int unsigned DB_COUNT  = 4
) (
   input  logic                   SYSCLK,
   input  logic                   RESET,
   input  logic [8*NUM_BYTES-1:0] RAW_IN,
   input  logic                   PORT_CS,
   input  logic [15:0]            OFFSET_SEL,
   input  logic                   RD_WR,
   input  logic [7:0]             WR_DATA,
   output logic [7:0]             DOUT,
   output logic [8*NUM_BYTES-1:0] STATUS,
   output logic                   CHG_PULSE
);

   localparam int unsigned NPINS     = 8 * NUM_BYTES;
   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
   localparam logic [3:0]  CNT_LAST  = 4'(DB_COUNT - 1);

   logic [NPINS-1:0] sync1;
   logic [NPINS-1:0] sync2;
   logic [NPINS-1:0] stable;
   logic [NPINS-1:0] en;
   logic [NPINS-1:0] status_prev;
   logic [3:0]       cnt [NPINS];
   logic [15:0]      presc;
   logic             tick;
   logic             rd_stb;
   logic             wr_stb;
   logic [7:0]       rd_byte;

   assign rd_stb = PORT_CS & RD_WR;
   assign wr_stb = PORT_CS & ~RD_WR;
   assign tick   = (presc == TICK_LAST);
   assign STATUS = stable & en;

   always_ff @(posedge SYSCLK) begin
      if (RESET) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= RAW_IN;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge SYSCLK) begin
      if (RESET || tick) begin
         presc <= '0;
      end else begin
         presc <= presc + 16'd1;
      end
   end

   // A pin must differ from its accepted level on DB_COUNT consecutive ticks
   // before the new level is taken; any matching tick restarts the count.
   always_ff @(posedge SYSCLK) begin
      if (RESET) begin
         stable <= '0;
         for (int unsigned i = 0; i < NPINS; i++) begin
            cnt[i] <= '0;
         end
      end else if (tick) begin
         for (int unsigned i = 0; i < NPINS; i++) begin
            if (sync2[i] != stable[i]) begin
               if (cnt[i] == CNT_LAST) begin
                  stable[i] <= sync2[i];
                  cnt[i]    <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 4'd1;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   always_ff @(posedge SYSCLK) begin
      if (RESET) begin
         en <= '1;
      end else if (wr_stb) begin
         for (int unsigned k = 0; k < NUM_BYTES; k++) begin
            if (OFFSET_SEL[NUM_BYTES + k]) begin
               en[8*k +: 8] <= WR_DATA;
            end
         end
      end
   end

   // Offsets are one-hot, so OR-combining the selected bytes is a plain mux.
   always_comb begin
      rd_byte = '0;
      for (int unsigned k = 0; k < NUM_BYTES; k++) begin
         if (OFFSET_SEL[k]) begin
            rd_byte = rd_byte | STATUS[8*k +: 8];
         end
         if (OFFSET_SEL[NUM_BYTES + k]) begin
            rd_byte = rd_byte | en[8*k +: 8];
         end
      end
   end

   always_ff @(posedge SYSCLK) begin
      if (RESET) begin
         DOUT <= '0;
      end else if (rd_stb) begin
         DOUT <= rd_byte;
      end
   end

   always_ff @(posedge SYSCLK) begin
      if (RESET) begin
         status_prev <= '0;
         CHG_PULSE   <= 1'b0;
      end else begin
         status_prev <= STATUS;
         CHG_PULSE   <= (STATUS != status_prev);
      end
   end

endmodule

// File: tb/tb_status_debounce.sv
// Directed bench for status_debounce with TICK_DIV=4, DB_COUNT=3, NUM_BYTES=2.
module tb_status_debounce;

   logic        SYSCLK;
   logic        RESET;
   logic [15:0] RAW_IN;
   logic        PORT_CS;
   logic [15:0] OFFSET_SEL;
   logic        RD_WR;
   logic [7:0]  WR_DATA;
   logic [7:0]  DOUT;
   logic [15:0] STATUS;
   logic        CHG_PULSE;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic        cs;
      logic        rd;
      logic [15:0] sel;
      logic [7:0]  wd;
      logic [15:0] e_status;
      logic [7:0]  e_dout;
      logic        e_chg;
   } vec_t;

   vec_t tbl [12];

   status_debounce #(
      .NUM_BYTES (2),
      .TICK_DIV  (4),
      .DB_COUNT  (3)
   ) dut (
      .SYSCLK     (SYSCLK),
      .RESET      (RESET),
      .RAW_IN     (RAW_IN),
      .PORT_CS    (PORT_CS),
      .OFFSET_SEL (OFFSET_SEL),
      .RD_WR      (RD_WR),
      .WR_DATA    (WR_DATA),
      .DOUT       (DOUT),
      .STATUS     (STATUS),
      .CHG_PULSE  (CHG_PULSE)
   );

   initial SYSCLK = 1'b0;
   always #5 SYSCLK = ~SYSCLK;

   task automatic step();
      @(posedge SYSCLK);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic idle_bus();
      PORT_CS    = 1'b0;
      RD_WR      = 1'b0;
      OFFSET_SEL = '0;
      WR_DATA    = '0;
   endtask

   task automatic bus(input logic cs, input logic rd, input logic [15:0] sel, input logic [7:0] wd);
      PORT_CS    = cs;
      RD_WR      = rd;
      OFFSET_SEL = sel;
      WR_DATA    = wd;
   endtask

   // Leaves the bench in cycle 0: first cycle with RESET low, prescaler at 0.
   task automatic do_reset(input logic [15:0] raw_after);
      RESET  = 1'b1;
      RAW_IN = '0;
      idle_bus();
      repeat (3) step();
      RESET  = 1'b0;
      RAW_IN = raw_after;
      cyc    = 0;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 16'h0004, 8'hFE, 16'h0100, 8'h00, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 16'h0100, 8'h00, 1'b1};
      tbl[2]  = '{1'b1, 1'b1, 16'h0001, 8'h00, 16'h0100, 8'h00, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 16'h0004, 8'h00, 16'h0100, 8'hFE, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 16'h0002, 8'h00, 16'h0100, 8'h01, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 16'h0001, 8'h00, 16'h0100, 8'h01, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 16'h0008, 8'h00, 16'h0100, 8'hFF, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 16'h0004, 8'hFF, 16'h0101, 8'hFF, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 16'h0101, 8'hFF, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 16'h0080, 8'hAA, 16'h0101, 8'hFF, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 16'h0080, 8'h00, 16'h0101, 8'h00, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 16'h0001, 8'h00, 16'h0101, 8'h01, 1'b0};

      // Reset with all pins high
      RESET  = 1'b1;
      RAW_IN = 16'hFFFF;
      idle_bus();
      repeat (3) begin
         step();
         check("rst_status", STATUS, 16'h0000);
         check("rst_dout", {8'h00, DOUT}, 16'h0000);
         check("rst_chg", {15'd0, CHG_PULSE}, 16'h0000);
      end
      RESET = 1'b0;
      cyc   = 0;
      check("rel_status", STATUS, 16'h0000);
      check("rel_dout", {8'h00, DOUT}, 16'h0000);
      check("rel_chg", {15'd0, CHG_PULSE}, 16'h0000);
      bus(1'b1, 1'b1, 16'h0004, 8'h00);
      step();
      check("rst_en0", {8'h00, DOUT}, 16'h00FF);
      bus(1'b1, 1'b1, 16'h0008, 8'h00);
      step();
      check("rst_en1", {8'h00, DOUT}, 16'h00FF);
      idle_bus();

      // Clean edge on pin 0
      do_reset(16'h0001);
      for (int i = 0; i < 21; i++) begin
         check("edge_status", STATUS, (cyc >= 12) ? 16'h0001 : 16'h0000);
         check("edge_chg", {15'd0, CHG_PULSE}, (cyc == 13) ? 16'h0001 : 16'h0000);
         step();
      end

      // Pin 5 glitch seen on only two ticks
      do_reset(16'h0020);
      for (int i = 0; i < 40; i++) begin
         if (cyc == 6) RAW_IN = '0;
         check("glitch_status", STATUS, 16'h0000);
         check("glitch_chg", {15'd0, CHG_PULSE}, 16'h0000);
         step();
      end

      // Mask and register map, table driven from cycle 14
      do_reset(16'h0101);
      while (cyc < 14) step();
      check("mask_pre", STATUS, 16'h0101);
      for (int i = 0; i < 12; i++) begin
         bus(tbl[i].cs, tbl[i].rd, tbl[i].sel, tbl[i].wd);
         step();
         idle_bus();
         check("tbl_status", STATUS, tbl[i].e_status);
         check("tbl_dout", {8'h00, DOUT}, {8'h00, tbl[i].e_dout});
         check("tbl_chg", {15'd0, CHG_PULSE}, {15'd0, tbl[i].e_chg});
      end

      // Read hold, and read coinciding with a STATUS update
      do_reset(16'hA500);
      while (cyc < 13) step();
      check("hold_pre", STATUS, 16'hA500);
      bus(1'b1, 1'b1, 16'h0002, 8'h00);
      step();
      idle_bus();
      RAW_IN = 16'h0000;
      while (cyc < 27) begin
         check("hold_dout", {8'h00, DOUT}, 16'h00A5);
         step();
      end
      check("hold_last_status", STATUS, 16'hA500);
      bus(1'b1, 1'b1, 16'h0002, 8'h00);
      step();
      check("coincide_dout", {8'h00, DOUT}, 16'h00A5);
      check("coincide_status", STATUS, 16'h0000);
      step();
      check("post_dout", {8'h00, DOUT}, 16'h0000);
      bus(1'b1, 1'b1, 16'h0008, 8'h00);
      step();
      check("hold_en1", {8'h00, DOUT}, 16'h00FF);
      bus(1'b1, 1'b1, 16'h0080, 8'h00);
      step();
      idle_bus();
      check("off7_dout", {8'h00, DOUT}, 16'h0000);

      // Reset mid-count on pin 3
      do_reset(16'h0008);
      while (cyc < 9) step();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      cyc   = 0;
      for (int i = 0; i < 13; i++) begin
         check("midrst_status", STATUS, (cyc >= 12) ? 16'h0008 : 16'h0000);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
